// File: rtl/instr_fetch_mem.sv
// rtl/instr_fetch_mem.sv - instruction fetch memory with fixed-latency response
// Optional program-load write port is enabled by defining IMEM_PROG_LOAD_EN.
module instr_fetch_mem #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    output logic              ready,
    output logic [DATA_W-1:0] instr,
    output logic              valid,
    output logic              err,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);
    localparam int IDX_W  = ADDR_W - 1;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W:0] DEPTH_L = (IDX_W + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state, state_next;
    logic [3:0]        count, count_next;
    logic [DATA_W-1:0] hold_data;
    logic              hold_err;
    logic              err_q;
    logic              accept;
    logic [IDX_W-1:0]  idx;
    logic              fault;
    logic [DATA_W-1:0] rd_data;

    // Words never loaded read as zero.
    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

    assign idx     = addr[ADDR_W-1:1];
    assign fault   = addr[0] | ({1'b0, idx} >= DEPTH_L);
    assign rd_data = fault ? '0 : mem[idx[MEM_AW-1:0]];

    assign ready  = ~reset & (state != WAIT);
    assign accept = req & ready;
    assign valid  = ~reset & (state == RESP);
    assign err    = valid & err_q;

    always_comb begin
        state_next = state;
        count_next = count;
        case (state)
            IDLE, RESP: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_next = RESP;
                        count_next = '0;
                    end else begin
                        state_next = WAIT;
                        count_next = 4'(LATENCY - 1);
                    end
                end else begin
                    state_next = IDLE;
                end
            end
            WAIT: begin
                if (count == 4'd1) begin
                    state_next = RESP;
                    count_next = '0;
                end else begin
                    count_next = count - 4'd1;
                end
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase
    end

    // Entering RESP straight from an accept only happens at LATENCY=1, so the
    // fresh read bypasses the holding register there.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            instr <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (accept) begin
                hold_data <= rd_data;
                hold_err  <= fault;
            end
            if (state_next == RESP) begin
                if (accept) begin
                    instr <= rd_data;
                    err_q <= fault;
                end else begin
                    instr <= hold_data;
                    err_q <= hold_err;
                end
            end
        end
    end

`ifdef IMEM_PROG_LOAD_EN
    logic [IDX_W-1:0] wr_idx;
    assign wr_idx = wr_addr[ADDR_W-1:1];

    // Non-blocking write keeps a same-edge fetch on the old contents.
    always_ff @(posedge clk) begin
        if (wr_en && !wr_addr[0] && ({1'b0, wr_idx} < DEPTH_L)) begin
            mem[wr_idx[MEM_AW-1:0]] <= wr_data;
        end
    end
`else
    logic unused_wr;
    assign unused_wr = ^{wr_en, wr_addr, wr_data};
`endif

endmodule

// File: tb/tb_instr_fetch_mem.sv
// tb/tb_instr_fetch_mem.sv - bench for instr_fetch_mem at LATENCY 2 and 1
// Build with IMEM_PROG_LOAD_EN defined to exercise the load port.
module tb_instr_fetch_mem;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          reset, req, wr_en;
    logic [AW-1:0] addr, wr_addr;
    logic [DW-1:0] wr_data;
    logic          ready2, valid2, err2, ready1, valid1, err1;
    logic [DW-1:0] instr2, instr1;

    always #5 clk = ~clk;

    instr_fetch_mem #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .LATENCY(2)) u2 (
        .clk(clk), .reset(reset), .req(req), .addr(addr), .ready(ready2),
        .instr(instr2), .valid(valid2), .err(err2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    instr_fetch_mem #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .LATENCY(1)) u1 (
        .clk(clk), .reset(reset), .req(req), .addr(addr), .ready(ready1),
        .instr(instr1), .valid(valid1), .err(err1),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    typedef struct {
        bit          rst;
        bit          rq;
        logic [AW-1:0] a;
        bit          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        bit          ev;
        bit          ee;
        logic [DW-1:0] ei;
        bit          er;
    } vec_t;

    vec_t vecs[$];

    logic [DW-1:0] exp_mem [DEPTH];
    int            m_due   [2];
    bit            m_resp  [2];
    bit            m_err   [2];
    bit            m_perr  [2];
    logic [DW-1:0] m_pend  [2];
    logic [DW-1:0] m_instr [2];

    int n_checks = 0;
    int n_pass = 0;

`ifdef IMEM_PROG_LOAD_EN
    localparam logic [DW-1:0] W4_AFTER = 16'hFFFF;
`else
    localparam logic [DW-1:0] W4_AFTER = 16'h1234;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference: a fetch is due LATENCY-1 edges after acceptance, then shows for one cycle.
    task automatic model_step();
        int            widx;
        bit            flt;
        logic [DW-1:0] rd;
        widx = int'(addr) / 2;
        flt  = addr[0] || (widx >= DEPTH);
        rd   = '0;
        if (!flt) rd = exp_mem[widx];
        for (int k = 0; k < 2; k++) begin
            int lat;
            bit rdy;
            lat = (k == 0) ? 2 : 1;
            rdy = !reset && (m_due[k] == 0);
            if (reset) begin
                m_due[k] = 0; m_resp[k] = 0; m_instr[k] = '0; m_err[k] = 0;
            end else if (req && rdy) begin
                if (lat == 1) begin
                    m_resp[k] = 1; m_instr[k] = rd; m_err[k] = flt;
                end else begin
                    m_resp[k] = 0; m_due[k] = lat - 1; m_pend[k] = rd; m_perr[k] = flt;
                end
            end else if (m_due[k] > 0) begin
                m_due[k]--;
                m_resp[k] = (m_due[k] == 0);
                if (m_resp[k]) begin
                    m_instr[k] = m_pend[k]; m_err[k] = m_perr[k];
                end
            end else begin
                m_resp[k] = 0;
            end
        end
`ifdef IMEM_PROG_LOAD_EN
        if (wr_en && !wr_addr[0] && (int'(wr_addr) / 2 < DEPTH))
            exp_mem[int'(wr_addr) / 2] = wr_data;
`endif
    endtask

    task automatic check_model();
        chk("u2_valid", 32'(valid2), 32'(m_resp[0]));
        chk("u2_err",   32'(err2),   32'(m_resp[0] && m_err[0]));
        chk("u2_instr", 32'(instr2), 32'(m_instr[0]));
        chk("u2_ready", 32'(ready2), 32'(!reset && m_due[0] == 0));
        chk("u1_valid", 32'(valid1), 32'(m_resp[1]));
        chk("u1_err",   32'(err1),   32'(m_resp[1] && m_err[1]));
        chk("u1_instr", 32'(instr1), 32'(m_instr[1]));
        chk("u1_ready", 32'(ready1), 32'(!reset && m_due[1] == 0));
    endtask

    task automatic cycle(input bit r, input bit rq, input logic [AW-1:0] a,
                         input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        @(negedge clk);
        reset = r; req = rq; addr = a; wr_en = we; wr_addr = wa; wr_data = wd;
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic load(input int idx, input logic [DW-1:0] v);
`ifdef IMEM_PROG_LOAD_EN
        cycle(0, 0, '0, 1, AW'(idx * 2), v);
`else
        u2.mem[idx] = v;
        u1.mem[idx] = v;
        exp_mem[idx] = v;
`endif
    endtask

    initial begin
        reset = 1; req = 0; addr = '0; wr_en = 0; wr_addr = '0; wr_data = '0;
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
        for (int k = 0; k < 2; k++) begin
            m_due[k] = 0; m_resp[k] = 0; m_err[k] = 0; m_perr[k] = 0;
            m_pend[k] = '0; m_instr[k] = '0;
        end

        cycle(1, 0, '0, 0, '0, '0);
        cycle(1, 0, '0, 0, '0, '0);
        cycle(0, 0, '0, 0, '0, '0);
        load(0, 16'h6100);
        load(1, 16'h6A01);
        load(4, 16'h1234);

        //             rst rq  addr       we  wa        wd        ev  ee  instr     rdy
        vecs.push_back('{1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0});
        vecs.push_back('{0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 1});
        vecs.push_back('{0, 1, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0});
        vecs.push_back('{0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 1, 0, 16'h6100, 1});
        vecs.push_back('{0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 16'h6100, 1});
        vecs.push_back('{0, 1, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 16'h6100, 0});
        vecs.push_back('{0, 1, 16'h0002, 0, 16'h0000, 16'h0000, 1, 0, 16'h6100, 1});
        vecs.push_back('{0, 1, 16'h0002, 0, 16'h0000, 16'h0000, 0, 0, 16'h6100, 0});
        vecs.push_back('{0, 1, 16'h0002, 0, 16'h0000, 16'h0000, 1, 0, 16'h6A01, 1});
        vecs.push_back('{0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 16'h6A01, 1});
        vecs.push_back('{0, 1, 16'h0003, 0, 16'h0000, 16'h0000, 0, 0, 16'h6A01, 0});
        vecs.push_back('{0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 1, 1, 16'h0000, 1});
        vecs.push_back('{0, 1, 16'h0200, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0});
        vecs.push_back('{0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 1, 1, 16'h0000, 1});
        vecs.push_back('{0, 1, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0});
        vecs.push_back('{0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 1, 0, 16'h6100, 1});
        vecs.push_back('{0, 1, 16'h0002, 0, 16'h0000, 16'h0000, 0, 0, 16'h6100, 0});
        vecs.push_back('{1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0});
        vecs.push_back('{0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 1});
        vecs.push_back('{0, 1, 16'h0002, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0});
        vecs.push_back('{0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 1, 0, 16'h6A01, 1});
        vecs.push_back('{0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 16'h6A01, 1});
        vecs.push_back('{0, 1, 16'h0008, 1, 16'h0008, 16'hFFFF, 0, 0, 16'h6A01, 0});
        vecs.push_back('{0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 1, 0, 16'h1234, 1});
        vecs.push_back('{0, 1, 16'h0008, 0, 16'h0000, 16'h0000, 0, 0, 16'h1234, 0});
        vecs.push_back('{0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 1, 0, W4_AFTER, 1});
        vecs.push_back('{0, 0, 16'h0000, 1, 16'h0009, 16'hBEEF, 0, 0, W4_AFTER, 1});
        vecs.push_back('{0, 0, 16'h0000, 1, 16'h0208, 16'hBEEF, 0, 0, W4_AFTER, 1});
        vecs.push_back('{0, 1, 16'h0008, 0, 16'h0000, 16'h0000, 0, 0, W4_AFTER, 0});
        vecs.push_back('{0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 1, 0, W4_AFTER, 1});

        foreach (vecs[i]) begin
            cycle(vecs[i].rst, vecs[i].rq, vecs[i].a, vecs[i].we, vecs[i].wa, vecs[i].wd);
            chk($sformatf("vec%0d_valid", i), 32'(valid2), 32'(vecs[i].ev));
            chk($sformatf("vec%0d_err", i),   32'(err2),   32'(vecs[i].ee));
            chk($sformatf("vec%0d_instr", i), 32'(instr2), 32'(vecs[i].ei));
            chk($sformatf("vec%0d_ready", i), 32'(ready2), 32'(vecs[i].er));
        end

        // LATENCY=1 sustains one response per cycle under continuous requests.
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, 16'h0000, 0, '0, '0);
            chk("lat1_stream_valid", 32'(valid1), 32'd1);
            chk("lat1_stream_instr", 32'(instr1), 32'h6100);
            chk("lat1_stream_ready", 32'(ready1), 32'd1);
        end

        for (int n = 0; n < 800; n++) begin
            bit            r, rq, we;
            logic [AW-1:0] a, wa;
            int            sel;
            r   = ($urandom_range(0, 49) == 0);
            rq  = ($urandom_range(0, 9) < 7);
            sel = $urandom_range(0, 9);
            if (sel < 6)       a = AW'(2 * $urandom_range(0, 7));
            else if (sel < 8)  a = AW'(2 * $urandom_range(0, 7) + 1);
            else if (sel == 8) a = AW'(16'h0200 + $urandom_range(0, 255));
            else               a = AW'($urandom);
            we  = ($urandom_range(0, 9) < 3);
            wa  = AW'($urandom_range(0, 17));
            if ($urandom_range(0, 7) == 0) wa = AW'(16'h0200 + $urandom_range(0, 15));
            cycle(r, rq, a, we, wa, DW'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/instr_fetch_mem.md
INSTR_FETCH_MEM -- requirements
Module: instr_fetch_mem

Interface
REQ-001 Parameter DATA_W, default 16, instruction width in bits.
REQ-002 Parameter ADDR_W, default 16, byte-address width.
REQ-003 Parameter DEPTH, default 256, number of instruction words.
REQ-004 Parameter LATENCY, default 2, cycles from request acceptance to valid; legal range 1..15.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 req  input  1  fetch request.
REQ-008 addr  input  ADDR_W  byte address of the fetch.
REQ-009 ready  output  1  block can accept a request this cycle.
REQ-010 instr  output  DATA_W  fetched instruction.
REQ-011 valid  output  1  one-cycle pulse; instr/err meaningful.
REQ-012 err  output  1  fetch faulted; qualified by valid.
REQ-013 wr_en  input  1  program-load write strobe (see Configuration).
REQ-014 wr_addr  input  ADDR_W  byte address of the load write.
REQ-015 wr_data  input  DATA_W  load write data.

Function
REQ-016 Word index SHALL be addr[ADDR_W-1:1]; the block is word-addressed on 2-byte alignment.
REQ-017 FSM SHALL have states IDLE, WAIT, RESP.
REQ-018 ready SHALL be 1 in IDLE and RESP, 0 in WAIT.
REQ-019 A request SHALL be accepted on a rising edge where req=1 and ready=1.
REQ-020 On acceptance, the memory word SHALL be read into a holding register at that edge (read-first); later writes SHALL NOT alter the pending result.
REQ-021 valid SHALL assert exactly LATENCY cycles after the accepting edge, for one cycle (RESP).
REQ-022 LATENCY=1: acceptance goes directly to RESP. LATENCY>1: acceptance goes to WAIT with a down-counter loaded with LATENCY-1; WAIT to RESP when the counter reaches 1.
REQ-023 RESP with an accepted request SHALL behave as acceptance from IDLE, giving one fetch per LATENCY cycles back-to-back; RESP without a request SHALL return to IDLE.
REQ-024 addr[0]=1 (misaligned) or word index >= DEPTH SHALL respond with err=1 and instr=0 at the normal latency; the memory is not read.
REQ-025 instr SHALL hold its last value between valid pulses; err SHALL be 0 whenever valid=0.
REQ-026 req while ready=0 SHALL be ignored; no queuing.

Reset
REQ-027 reset=1 SHALL force IDLE, counter=0, valid=0, err=0, instr=0, ready=0 during the reset cycle and 1 after it, regardless of state; an in-flight fetch is dropped with no valid.
REQ-028 Memory contents SHALL NOT be altered by reset.

Configuration
REQ-029 Macro IMEM_PROG_LOAD_EN defined: on an edge with wr_en=1, aligned wr_addr, and index < DEPTH, the block SHALL write wr_data to the word; misaligned or out-of-range writes SHALL be dropped silently. A write and an accepted fetch to the same word on one edge SHALL return the old data.
REQ-030 Macro undefined: wr_en, wr_addr and wr_data SHALL be ignored; the memory is read-only after simulation initialisation, with all words not otherwise initialised equal to 0.

Verification
REQ-031 LATENCY=2; load word 0=0x6100 and word 1=0x6A01; req at addr 0x0000 -> valid with instr=0x6100 two cycles later, err=0.
REQ-032 LATENCY=2; req held high with addr 0,2 back-to-back -> valid every 2 cycles with 0x6100 then 0x6A01; ready low only in the WAIT cycles.
REQ-033 req at addr 0x0003 and at addr 0x0200 (DEPTH=256) -> valid with err=1 and instr=0 at normal latency.
REQ-034 With IMEM_PROG_LOAD_EN: same-edge write 0xFFFF and fetch of word 4 -> old value returned; a second fetch returns 0xFFFF.
REQ-035 reset asserted during WAIT -> no valid pulse; outputs zero; a fetch after reset returns the same memory data as before reset.
REQ-036 LATENCY=1 -> valid on the cycle after acceptance; sustained requests give one valid per cycle.
